uart_word_streamer: RTL and testbench

- Serialises a wide data word onto a UART line as a sequence of 8N1 (or 8N2) bytes.
- Has its own internal baud divider, so no derived slow clock is needed.
- Sits between wide producers (e.g. the chacha20 512-bit keystream block) and the FTDI tx pin, and replaces per-byte sequencing in top-level glue.
- Supports a parametrised word width, a programmable byte count, byte order, stop-bit count and abort.

---
 rtl/uart_word_streamer_if.sv | 27 ++
 rtl/uart_word_streamer.sv | 171 +++++++++++++++++
 tb/tb_uart_word_streamer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/uart_word_streamer_if.sv
// Handshake and line signals between a word producer and uart_word_streamer.
// The producer side uses the master modport, the streamer uses the slave one.
interface uart_word_streamer_if #(
    parameter int WORD_BITS = 512
);
    localparam int LEN_W = $clog2(WORD_BITS / 8 + 1);

    logic                 start;
    logic [WORD_BITS-1:0] data;
    logic [LEN_W-1:0]     len;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [LEN_W-1:0]     byte_idx;
    logic                 tx;

    modport master (
        output start, data, len, abort,
        input  busy, done, aborted, byte_idx, tx
    );

    modport slave (
        input  start, data, len, abort,
        output busy, done, aborted, byte_idx, tx
    );
endinterface

// File: rtl/uart_word_streamer.sv
// Serialises a WORD_BITS-wide word onto a UART line as len back-to-back 8N1/8N2
// frames, using an internal baud counter so no divided clock is needed.
module uart_word_streamer #(
    parameter int CLK_HZ    = 12000000,
    parameter int BAUD      = 9600,
    parameter int WORD_BITS = 512,
    parameter int LSB_FIRST = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    uart_word_streamer_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int NBYTES       = WORD_BITS / 8;
    localparam int LEN_W        = $clog2(NBYTES + 1);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LEN_W-1:0] LEN_MAX     = LEN_W'(NBYTES);
    // Index of the final stop bit (0 for one stop bit, 1 for two).
    localparam logic             STOP_LAST   = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t               r_state;
    logic [WORD_BITS-1:0] r_shift;
    logic [LEN_W-1:0]     r_remaining;
    logic [LEN_W-1:0]     r_byte_idx;
    logic [CNT_W-1:0]     r_baud;
    logic [2:0]           r_bit;
    logic                 r_stop;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_aborted;

    logic [LEN_W-1:0]     w_len_clamped;
    logic [7:0]           w_cur_byte;
    logic [WORD_BITS-1:0] w_shifted;
    logic                 w_baud_zero;

    // Oversized requests saturate at the word size rather than wrapping.
    assign w_len_clamped = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    assign w_baud_zero   = (r_baud == '0);

    // The byte on the line always sits at the sending end of the shift
    // register; after each frame the register moves 8 bits toward that end.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign w_cur_byte = r_shift[7:0];
            assign w_shifted  = r_shift >> 8;
        end else begin : g_msb_first
            assign w_cur_byte = r_shift[WORD_BITS-1 -: 8];
            assign w_shifted  = r_shift << 8;
        end
    endgenerate

    // Transfer sequencer: frame state, baud timing and all registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_baud      <= '0;
            r_bit       <= '0;
            r_stop      <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (r_busy && bus.abort) begin
                // Truncate any partial frame; byte_idx keeps completed bytes.
                r_state   <= S_IDLE;
                r_tx      <= 1'b1;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_byte_idx <= '0;
                            if (w_len_clamped != '0) begin
                                r_shift     <= bus.data;
                                r_remaining <= w_len_clamped;
                                r_baud      <= BAUD_RELOAD;
                                r_state     <= S_START;
                                r_tx        <= 1'b0;
                                r_busy      <= 1'b1;
                            end else begin
                                // Empty request completes without line activity.
                                r_state <= S_FINISH;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    S_START: begin
                        if (!w_baud_zero) begin
                            r_baud <= r_baud - 1'b1;
                        end else begin
                            r_baud  <= BAUD_RELOAD;
                            r_bit   <= '0;
                            r_tx    <= w_cur_byte[0];
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (!w_baud_zero) begin
                            r_baud <= r_baud - 1'b1;
                        end else begin
                            r_baud <= BAUD_RELOAD;
                            if (r_bit == 3'd7) begin
                                r_tx    <= 1'b1;
                                r_stop  <= 1'b0;
                                r_state <= S_STOP;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                                r_tx  <= w_cur_byte[r_bit + 3'd1];
                            end
                        end
                    end
                    S_STOP: begin
                        if (!w_baud_zero) begin
                            r_baud <= r_baud - 1'b1;
                        end else begin
                            r_baud <= BAUD_RELOAD;
                            if (r_stop == STOP_LAST) begin
                                r_byte_idx  <= r_byte_idx + 1'b1;
                                r_remaining <= r_remaining - 1'b1;
                                r_shift     <= w_shifted;
                                if (r_remaining > LEN_W'(1)) begin
                                    // Next start bit follows with no idle gap.
                                    r_tx    <= 1'b0;
                                    r_state <= S_START;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_FINISH;
                                end
                            end else begin
                                r_stop <= 1'b1;
                            end
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.aborted  = r_aborted;
    assign bus.byte_idx = r_byte_idx;
endmodule

// File: tb/tb_uart_word_streamer.sv
// Bench for uart_word_streamer: two instances (LSB-first/1 stop bit and
// MSB-first/2 stop bits) run the same stimulus and are compared every cycle
// against a waveform computed from frame arithmetic.
module tb_uart_word_streamer;
    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    uart_word_streamer_if #(.WORD_BITS(32)) if_a ();
    uart_word_streamer_if #(.WORD_BITS(32)) if_b ();

    uart_word_streamer #(
        .CLK_HZ(16), .BAUD(1), .WORD_BITS(32), .LSB_FIRST(1), .STOP_BITS(1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if_a)
    );

    uart_word_streamer #(
        .CLK_HZ(16), .BAUD(1), .WORD_BITS(32), .LSB_FIRST(0), .STOP_BITS(2)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [31:0] d, input logic [2:0] l,
                         input logic ab);
        if_a.start = st; if_a.data = d; if_a.len = l; if_a.abort = ab;
        if_b.start = st; if_b.data = d; if_b.len = l; if_b.abort = ab;
    endtask

    // Reference: line and status at cycle k after a start issued in cycle 0.
    function automatic void expect_at(input int cfg, input logic [31:0] d, input int n,
                                      input int k, input int abort_at, input int rst_at,
                                      output logic e_tx, output logic e_busy,
                                      output logic e_done, output logic e_ab,
                                      output int e_idx);
        int frame, tot, pos, f, b;
        logic [7:0] byt;
        frame  = (cfg == 0) ? 10 * CPB : 11 * CPB;
        tot    = n * frame;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_ab   = 1'b0;
        e_idx  = 0;
        if (rst_at >= 0 && k >= rst_at) begin
            e_idx = 0;
        end else if (abort_at >= 0 && k > abort_at) begin
            e_idx = (abort_at - 1) / frame;
            e_ab  = (k == abort_at + 1);
        end else if (n == 0) begin
            e_done = (k == 1);
        end else if (k <= tot) begin
            pos    = k - 1;
            f      = pos / frame;
            b      = (pos % frame) / CPB;
            byt    = (cfg == 0) ? 8'(d >> (8 * f)) : 8'(d >> (8 * (3 - f)));
            e_busy = 1'b1;
            e_idx  = f;
            if (b == 0)      e_tx = 1'b0;
            else if (b <= 8) e_tx = byt[b-1];
            else             e_tx = 1'b1;
        end else begin
            e_done = (k == tot + 1);
            e_idx  = n;
        end
    endfunction

    task automatic run_xfer(input string name, input logic [31:0] d, input int ln,
                            input int abort_at, input int rst_at, input int extra_at,
                            input logic ab_with_start);
        int   n, tot_b, cut, kmax, e_idx, done_cnt;
        logic e_tx, e_busy, e_done, e_ab;
        logic o_tx, o_busy, o_done, o_ab;
        int   o_idx;
        n        = (ln > 4) ? 4 : ln;
        tot_b    = n * 11 * CPB;
        cut      = (abort_at >= 0) ? abort_at : rst_at;
        kmax     = (cut >= 0) ? cut + 4 : tot_b + 3;
        done_cnt = 0;
        @(posedge clk); #1;
        drive(1'b1, d, 3'(ln), ab_with_start);
        for (int k = 1; k <= kmax; k++) begin
            @(posedge clk); #1;
            drive(k == extra_at, $urandom, 3'($urandom),
                  (k == abort_at) || (cut >= 0 && k > cut) || (k > tot_b) ? 
                  ((k == abort_at) ? 1'b1 : 1'($urandom)) : 1'b0);
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk($sformatf("%s rst_tx_a", name), int'(if_a.tx), 1);
                chk($sformatf("%s rst_busy_a", name), int'(if_a.busy), 0);
                chk($sformatf("%s rst_tx_b", name), int'(if_b.tx), 1);
                chk($sformatf("%s rst_busy_b", name), int'(if_b.busy), 0);
            end
            if (rst_at >= 0 && k == rst_at + 2) rst_n = 1'b1;
            @(negedge clk);
            for (int cfg = 0; cfg < 2; cfg++) begin
                expect_at(cfg, d, n, k, abort_at, rst_at, e_tx, e_busy, e_done, e_ab, e_idx);
                o_tx   = (cfg == 0) ? if_a.tx       : if_b.tx;
                o_busy = (cfg == 0) ? if_a.busy     : if_b.busy;
                o_done = (cfg == 0) ? if_a.done     : if_b.done;
                o_ab   = (cfg == 0) ? if_a.aborted  : if_b.aborted;
                o_idx  = (cfg == 0) ? int'(if_a.byte_idx) : int'(if_b.byte_idx);
                if (o_done && cfg == 0) done_cnt++;
                chk($sformatf("%s c%0d k=%0d tx", name, cfg, k), int'(o_tx), int'(e_tx));
                chk($sformatf("%s c%0d k=%0d busy", name, cfg, k), int'(o_busy), int'(e_busy));
                chk($sformatf("%s c%0d k=%0d done", name, cfg, k), int'(o_done), int'(e_done));
                chk($sformatf("%s c%0d k=%0d aborted", name, cfg, k), int'(o_ab), int'(e_ab));
                chk($sformatf("%s c%0d k=%0d byte_idx", name, cfg, k), o_idx, e_idx);
            end
        end
        chk($sformatf("%s done_count", name), done_cnt, (cut >= 0) ? 0 : 1);
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        $display("xfer %s data=%08h len=%0d abort_at=%0d rst_at=%0d extra_at=%0d", name, d,
                 ln, abort_at, rst_at, extra_at);
    endtask

    initial begin
        int ln, n, ab, ex, rs;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx_a", int'(if_a.tx), 1);
        chk("reset busy_a", int'(if_a.busy), 0);
        chk("reset done_a", int'(if_a.done), 0);
        chk("reset aborted_a", int'(if_a.aborted), 0);
        chk("reset byte_idx_a", int'(if_a.byte_idx), 0);
        chk("reset tx_b", int'(if_b.tx), 1);
        chk("reset byte_idx_b", int'(if_b.byte_idx), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_xfer("basic", 32'hA5C30F01, 4, -1, -1, -1, 1'b0);
        run_xfer("len0", 32'h12345678, 0, -1, -1, -1, 1'b0);
        run_xfer("clamp", 32'hA5C30F01, 7, -1, -1, -1, 1'b0);
        run_xfer("abort", 32'hA5C30F01, 4, 200, -1, -1, 1'b0);
        run_xfer("after_abort", 32'h5A3CF010, 4, -1, -1, -1, 1'b0);
        run_xfer("ignore_start", 32'hDEADBEEF, 4, -1, -1, 50, 1'b0);
        run_xfer("reset", 32'hCAFEF00D, 4, -1, 300, -1, 1'b0);
        run_xfer("after_reset", 32'h0BADC0DE, 4, -1, -1, -1, 1'b0);
        run_xfer("start_abort", 32'h80C0E0F1, 3, -1, -1, -1, 1'b1);

        for (int i = 0; i < 14; i++) begin
            ln = $urandom_range(0, 7);
            n  = (ln > 4) ? 4 : ln;
            ab = -1;
            ex = -1;
            rs = -1;
            if (n > 0) begin
                case ($urandom_range(0, 3))
                    0: ab = $urandom_range(1, n * 10 * CPB);
                    1: ex = $urandom_range(2, n * 10 * CPB);
                    2: rs = $urandom_range(1, n * 10 * CPB);
                    default: ;
                endcase
            end
            run_xfer($sformatf("rand%0d", i), $urandom, ln, ab, rs, ex, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
